// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port byte-wide RAM controller arbitrating between
// instruction-fetch bursts and load/store-buffer transactions. Words are
// assembled from / split into bytes little-endian, one byte per cycle.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int unsigned FETCH_WORDS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        enable_from_fetcher,
   input  logic [31:0] addr_from_fetcher,
   input  logic        reset_from_fetcher,
   output logic        available_to_fetcher,
   output logic        one_inst_finish_to_fetcher,
   output logic        end_to_fetcher,
   output logic [31:0] inst_to_fetcher,
   input  logic        req_from_lsb,
   input  logic        wr_from_lsb,
   input  logic [31:0] addr_from_lsb,
   input  logic [2:0]  size_from_lsb,
   input  logic [31:0] wdata_from_lsb,
   output logic        done_to_lsb,
   output logic [31:0] rdata_to_lsb,
   input  logic        rollback_flag_from_rob
);

   // Byte count of a full burst; cnt reaches this value in the final capture-only cycle.
   localparam logic [6:0] LAST_BYTE = 7'(4 * FETCH_WORDS);

   typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_t;

   state_t      state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [2:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] rdata_q, rdata_d;
   logic        one_inst_q, one_inst_d;
   logic        end_q, end_d;
   logic        done_q, done_d;
   logic        last_lsb_q, last_lsb_d;

   logic        blocked, lsb_req, fetch_req, grant_lsb, grant_fetch, io_stall;
   logic [1:0]  byte_lane;
   logic [31:0] cap_word;
   logic [7:0]  store_byte;
   logic [6:0]  cnt_next;
   logic [6:0]  size_ext;

   // Requests are ignored while a completion pulse is out; a rollback kills a pending load.
   assign blocked     = done_q | end_q;
   assign lsb_req     = req_from_lsb & ~blocked & ~(rollback_flag_from_rob & ~wr_from_lsb);
   assign fetch_req   = enable_from_fetcher & ~blocked;
   assign grant_lsb   = lsb_req & (~fetch_req | ~last_lsb_q);
   assign grant_fetch = fetch_req & ~grant_lsb;
   assign io_stall    = (addr_q[17:16] == 2'b11) & io_buffer_full;
   assign byte_lane   = cnt_q[1:0] - 2'd1;
   assign cnt_next    = cnt_q + 7'd1;
   assign size_ext    = {4'b0000, size_q};

   // Byte lane muxing: merge the returning read byte, select the outgoing store byte.
   always_comb begin
      cap_word = asm_q;
      unique case (byte_lane)
         2'd0: cap_word[7:0]   = mem_din;
         2'd1: cap_word[15:8]  = mem_din;
         2'd2: cap_word[23:16] = mem_din;
         2'd3: cap_word[31:24] = mem_din;
      endcase
      unique case (cnt_q[1:0])
         2'd0: store_byte = wdata_q[7:0];
         2'd1: store_byte = wdata_q[15:8];
         2'd2: store_byte = wdata_q[23:16];
         2'd3: store_byte = wdata_q[31:24];
      endcase
   end

   // Next-state, sequencing and RAM write strobes.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      size_d     = size_q;
      wdata_d    = wdata_q;
      asm_d      = asm_q;
      addr_d     = addr_q;
      inst_d     = inst_q;
      rdata_d    = rdata_q;
      last_lsb_d = last_lsb_q;
      one_inst_d = 1'b0;
      end_d      = 1'b0;
      done_d     = 1'b0;
      mem_wr     = 1'b0;
      mem_dout   = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (grant_lsb) begin
               state_d    = wr_from_lsb ? StStore : StLoad;
               size_d     = size_from_lsb;
               wdata_d    = wdata_from_lsb;
               addr_d     = addr_from_lsb;
               cnt_d      = 7'd0;
               asm_d      = 32'h0;
               last_lsb_d = 1'b1;
            end else if (grant_fetch) begin
               state_d    = StFetch;
               addr_d     = addr_from_fetcher;
               cnt_d      = 7'd0;
               asm_d      = 32'h0;
               last_lsb_d = 1'b0;
            end
         end
         StFetch: begin
            if (reset_from_fetcher) begin
               state_d = StIdle;
            end else begin
               // Byte cnt-1 arrives this cycle, one cycle behind its address.
               if (cnt_q != 7'd0) begin
                  asm_d = cap_word;
                  if (byte_lane == 2'd3) begin
                     inst_d = cap_word;
                     if (cnt_q == LAST_BYTE) end_d = 1'b1;
                     else                    one_inst_d = 1'b1;
                  end
               end
               if (cnt_q == LAST_BYTE) begin
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_next;
                  if (cnt_next < LAST_BYTE) addr_d = addr_q + 32'd1;
               end
            end
         end
         StLoad: begin
            if (rollback_flag_from_rob) begin
               state_d = StIdle;
            end else begin
               if (cnt_q != 7'd0) asm_d = cap_word;
               if (cnt_q == size_ext) begin
                  rdata_d = cap_word;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_next;
                  if (cnt_next < size_ext) addr_d = addr_q + 32'd1;
               end
            end
         end
         StStore: begin
            mem_dout = store_byte;
            if (!io_stall) begin
               mem_wr = rdy_in;
               if (cnt_next == size_ext) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  cnt_d  = cnt_next;
                  addr_d = addr_q + 32'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; rdy_in low freezes everything.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= StIdle;
         cnt_q      <= 7'd0;
         size_q     <= 3'd0;
         wdata_q    <= 32'h0;
         asm_q      <= 32'h0;
         addr_q     <= 32'h0;
         inst_q     <= 32'h0;
         rdata_q    <= 32'h0;
         one_inst_q <= 1'b0;
         end_q      <= 1'b0;
         done_q     <= 1'b0;
         last_lsb_q <= 1'b0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         asm_q      <= asm_d;
         addr_q     <= addr_d;
         inst_q     <= inst_d;
         rdata_q    <= rdata_d;
         one_inst_q <= one_inst_d;
         end_q      <= end_d;
         done_q     <= done_d;
         last_lsb_q <= last_lsb_d;
      end
   end

   assign mem_a                      = addr_q;
   assign available_to_fetcher       = (state_q == StIdle);
   assign one_inst_finish_to_fetcher = one_inst_q;
   assign end_to_fetcher             = end_q;
   assign inst_to_fetcher            = inst_q;
   assign done_to_lsb                = done_q;
   assign rdata_to_lsb               = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a one-cycle-latency byte RAM model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic [7:0]  mem_din = 8'h00;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        enable_from_fetcher;
   logic [31:0] addr_from_fetcher;
   logic        reset_from_fetcher;
   logic        available_to_fetcher;
   logic        one_inst_finish_to_fetcher;
   logic        end_to_fetcher;
   logic [31:0] inst_to_fetcher;
   logic        req_from_lsb, wr_from_lsb;
   logic [31:0] addr_from_lsb;
   logic [2:0]  size_from_lsb;
   logic [31:0] wdata_from_lsb;
   logic        done_to_lsb;
   logic [31:0] rdata_to_lsb;
   logic        rollback_flag_from_rob;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_words [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
   logic [31:0] st_word;

   mem_arbiter #(.FETCH_WORDS(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full),
      .enable_from_fetcher(enable_from_fetcher), .addr_from_fetcher(addr_from_fetcher),
      .reset_from_fetcher(reset_from_fetcher), .available_to_fetcher(available_to_fetcher),
      .one_inst_finish_to_fetcher(one_inst_finish_to_fetcher),
      .end_to_fetcher(end_to_fetcher), .inst_to_fetcher(inst_to_fetcher),
      .req_from_lsb(req_from_lsb), .wr_from_lsb(wr_from_lsb), .addr_from_lsb(addr_from_lsb),
      .size_from_lsb(size_from_lsb), .wdata_from_lsb(wdata_from_lsb),
      .done_to_lsb(done_to_lsb), .rdata_to_lsb(rdata_to_lsb),
      .rollback_flag_from_rob(rollback_flag_from_rob)
   );

   always #5 clk_in = ~clk_in;

   // RAM contents: low address byte, except two bytes used by the size-2 load.
   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      if (a == 32'h0000_2002) return 8'h34;
      if (a == 32'h0000_2003) return 8'h12;
      return a[7:0];
   endfunction

   // Read data appears one cycle after its address; frozen while rdy_in is low.
   always @(posedge clk_in) if (rdy_in) mem_din <= ram_byte(mem_a);

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Follows a fetch burst from cycle 1 to its end (cycle 17); rollback asserted in [rb_first, rb_last].
   task automatic run_burst(input int rb_first, input int rb_last);
      for (int c = 1; c <= 17; c++) begin
         tick();
         rollback_flag_from_rob = (c >= rb_first) && (c <= rb_last);
         check("burst_one_inst", {31'b0, one_inst_finish_to_fetcher},
               (c == 5 || c == 9 || c == 13) ? 32'd1 : 32'd0);
         check("burst_end", {31'b0, end_to_fetcher}, (c == 17) ? 32'd1 : 32'd0);
         if (c >= 5 && (c % 4) == 1) check("burst_word", inst_to_fetcher, exp_words[(c - 5) / 4]);
         if (c == 17) begin
            check("burst_avail_at_end", {31'b0, available_to_fetcher}, 32'd1);
            enable_from_fetcher = 1'b0;
         end
      end
      rollback_flag_from_rob = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
      enable_from_fetcher = 1'b0; addr_from_fetcher = 32'h0; reset_from_fetcher = 1'b0;
      req_from_lsb = 1'b0; wr_from_lsb = 1'b0; addr_from_lsb = 32'h0; size_from_lsb = 3'd0;
      wdata_from_lsb = 32'h0; rollback_flag_from_rob = 1'b0;
      #1;
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
      check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
      check("rst_avail", {31'b0, available_to_fetcher}, 32'd1);
      check("rst_one_inst", {31'b0, one_inst_finish_to_fetcher}, 32'd0);
      check("rst_end", {31'b0, end_to_fetcher}, 32'd0);
      check("rst_done", {31'b0, done_to_lsb}, 32'd0);
      check("rst_inst", inst_to_fetcher, 32'h0);
      check("rst_rdata", rdata_to_lsb, 32'h0);
      tick(); tick();
      rst_in = 1'b0;
      tick();

      // Tie right after reset: LSB (size-2 load) first, then the fetch burst.
      enable_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_1000;
      req_from_lsb = 1'b1; wr_from_lsb = 1'b0; addr_from_lsb = 32'h0000_2002; size_from_lsb = 3'd2;
      tick();
      check("tie1_lsb_avail", {31'b0, available_to_fetcher}, 32'd0);
      check("tie1_lsb_addr", mem_a, 32'h0000_2002);
      tick();
      check("load2_addr1", mem_a, 32'h0000_2003);
      tick();
      check("load2_no_done_c2", {31'b0, done_to_lsb}, 32'd0);
      tick();
      check("load2_done_c3", {31'b0, done_to_lsb}, 32'd1);
      check("load2_rdata", rdata_to_lsb, 32'h0000_1234);
      req_from_lsb = 1'b0;
      tick();
      check("tie1_fetch_blocked", {31'b0, available_to_fetcher}, 32'd1);
      check("load2_done_1cyc", {31'b0, done_to_lsb}, 32'd0);
      tick();
      check("tie1_fetch_grant", {31'b0, available_to_fetcher}, 32'd0);
      check("tie1_fetch_addr", mem_a, 32'h0000_1000);
      run_burst(0, -1);

      // Size-4 load alone.
      tick();
      req_from_lsb = 1'b1; wr_from_lsb = 1'b0; addr_from_lsb = 32'h0000_2004; size_from_lsb = 3'd4;
      tick();
      check("load4_addr0", mem_a, 32'h0000_2004);
      for (int c = 1; c <= 5; c++) begin
         tick();
         check("load4_done", {31'b0, done_to_lsb}, (c == 5) ? 32'd1 : 32'd0);
      end
      check("load4_rdata", rdata_to_lsb, 32'h0706_0504);

      // Second tie after an LSB grant: fetch wins; then abort it mid-burst.
      req_from_lsb = 1'b1; wr_from_lsb = 1'b1; addr_from_lsb = 32'h0003_0000;
      size_from_lsb = 3'd1; wdata_from_lsb = 32'h0000_0041; io_buffer_full = 1'b1;
      enable_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_1000;
      tick();
      check("tie2_idle", {31'b0, available_to_fetcher}, 32'd1);
      tick();
      check("tie2_fetch_addr", mem_a, 32'h0000_1000);
      check("tie2_no_write", {31'b0, mem_wr}, 32'd0);
      repeat (4) tick();
      reset_from_fetcher = 1'b1; enable_from_fetcher = 1'b0;
      tick();
      check("abort_idle", {31'b0, available_to_fetcher}, 32'd1);
      check("abort_no_pulse", {31'b0, one_inst_finish_to_fetcher}, 32'd0);
      reset_from_fetcher = 1'b0;

      // IO store stalled for three cycles.
      tick();
      check("io_st_avail", {31'b0, available_to_fetcher}, 32'd0);
      check("io_st_addr", mem_a, 32'h0003_0000);
      check("io_st_stall_c0", {31'b0, mem_wr}, 32'd0);
      tick();
      check("io_st_stall_c1", {31'b0, mem_wr}, 32'd0);
      tick();
      check("io_st_stall_c2", {31'b0, mem_wr}, 32'd0);
      tick();
      io_buffer_full = 1'b0;
      #1;
      check("io_st_wr_c3", {31'b0, mem_wr}, 32'd1);
      check("io_st_dout", {24'b0, mem_dout}, 32'h41);
      check("io_st_addr_c3", mem_a, 32'h0003_0000);
      check("io_st_no_done_c3", {31'b0, done_to_lsb}, 32'd0);
      tick();
      check("io_st_done_c4", {31'b0, done_to_lsb}, 32'd1);
      check("io_st_wr_off", {31'b0, mem_wr}, 32'd0);
      req_from_lsb = 1'b0;

      // Word store to RAM; request data changed after grant must not matter.
      tick();
      req_from_lsb = 1'b1; wr_from_lsb = 1'b1; addr_from_lsb = 32'h0000_0100;
      size_from_lsb = 3'd4; wdata_from_lsb = 32'hDDCC_BBAA;
      st_word = 32'hDDCC_BBAA;
      tick();
      wdata_from_lsb = 32'h1111_1111;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         check("st4_wr", {31'b0, mem_wr}, 32'd1);
         check("st4_addr", mem_a, 32'h0000_0100 + 32'(c));
         check("st4_dout", {24'b0, mem_dout}, (st_word >> (8 * c)) & 32'hFF);
         check("st4_no_done", {31'b0, done_to_lsb}, 32'd0);
      end
      tick();
      check("st4_done_c4", {31'b0, done_to_lsb}, 32'd1);
      check("st4_wr_off", {31'b0, mem_wr}, 32'd0);
      req_from_lsb = 1'b0;

      // Rollback in cycle 2 of a size-4 load with a fetch pending.
      tick();
      req_from_lsb = 1'b1; wr_from_lsb = 1'b0; addr_from_lsb = 32'h0000_2004; size_from_lsb = 3'd4;
      tick();
      enable_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_1000;
      tick();
      tick();
      rollback_flag_from_rob = 1'b1;
      check("rb_no_done_c2", {31'b0, done_to_lsb}, 32'd0);
      tick();
      check("rb_idle_c3", {31'b0, available_to_fetcher}, 32'd1);
      check("rb_no_done_c3", {31'b0, done_to_lsb}, 32'd0);
      tick();
      check("rb_fetch_grant", mem_a, 32'h0000_1000);
      check("rb_fetch_busy", {31'b0, available_to_fetcher}, 32'd0);
      check("rb_no_done_c4", {31'b0, done_to_lsb}, 32'd0);
      req_from_lsb = 1'b0; rollback_flag_from_rob = 1'b0;
      run_burst(2, 3);

      // rdy_in low freezes a store and masks mem_wr.
      tick();
      req_from_lsb = 1'b1; wr_from_lsb = 1'b1; addr_from_lsb = 32'h0000_0200;
      size_from_lsb = 3'd1; wdata_from_lsb = 32'h0000_0055;
      tick();
      rdy_in = 1'b0;
      #1;
      check("rdy_wr_masked", {31'b0, mem_wr}, 32'd0);
      tick();
      check("rdy_frozen_wr", {31'b0, mem_wr}, 32'd0);
      check("rdy_frozen_addr", mem_a, 32'h0000_0200);
      check("rdy_frozen_done", {31'b0, done_to_lsb}, 32'd0);
      rdy_in = 1'b1;
      #1;
      check("rdy_resume_wr", {31'b0, mem_wr}, 32'd1);
      check("rdy_resume_dout", {24'b0, mem_dout}, 32'h55);
      tick();
      check("rdy_done", {31'b0, done_to_lsb}, 32'd1);
      req_from_lsb = 1'b0;

      // Asynchronous reset in cycle 6 of a burst.
      tick();
      enable_from_fetcher = 1'b1; addr_from_fetcher = 32'h0000_1000;
      tick();
      repeat (6) tick();
      check("mid_inst_held", inst_to_fetcher, 32'h0302_0100);
      check("mid_one_inst_low", {31'b0, one_inst_finish_to_fetcher}, 32'd0);
      #3;
      rst_in = 1'b1;
      #1;
      check("arst_mem_a", mem_a, 32'h0);
      check("arst_avail", {31'b0, available_to_fetcher}, 32'd1);
      check("arst_inst", inst_to_fetcher, 32'h0);
      check("arst_wr", {31'b0, mem_wr}, 32'd0);
      check("arst_dout", {24'b0, mem_dout}, 32'h0);
      enable_from_fetcher = 1'b0;
      for (int c = 0; c < 14; c++) begin
         tick();
         check("arst_no_end", {31'b0, end_to_fetcher}, 32'd0);
      end
      rst_in = 1'b0;
      tick();
      check("arst_idle_after", {31'b0, available_to_fetcher}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM controller and arbiter between the instruction Fetcher (burst word reads that fill its icache) and the load/store buffer (committed stores, speculative loads). It sequences the byte-wide RAM interface, one byte per cycle, and assembles or splits words little-endian. It sits between the core and the external RAM/IO bus, replacing direct Fetcher-to-RAM access.

## Interface
- FETCH_WORDS, 4: words per fetch burst (1..16).
- clk_in  in  1  clock; all state on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state, forces mem_wr low.
- mem_din  in  8  RAM read data, valid one cycle after its address.
- mem_dout  out  8  RAM write data.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  IO write buffer full; stalls stores to IO space (mem_a[17:16]==2'b11).
- enable_from_fetcher  in  1  fetch burst request (level).
- addr_from_fetcher  in  32  burst base address (word-aligned).
- reset_from_fetcher  in  1  abort current burst.
- available_to_fetcher  out  1  controller idle, may accept a burst.
- one_inst_finish_to_fetcher  out  1  non-final word valid (pulse).
- end_to_fetcher  out  1  final word valid (pulse).
- inst_to_fetcher  out  32  assembled word.
- req_from_lsb  in  1  load/store request (level).
- wr_from_lsb  in  1  1 = store.
- addr_from_lsb  in  32  byte address.
- size_from_lsb  in  3  bytes: 1, 2 or 4.
- wdata_from_lsb  in  32  store data, byte 0 = bits 7:0.
- done_to_lsb  out  1  transaction complete (pulse).
- rdata_to_lsb  out  32  load data, zero-extended.
- rollback_flag_from_rob  in  1  misprediction flush.

## Operation
- States: IDLE, FETCH, LOAD, STORE. Byte counter cnt, word counter wcnt, latched base address/size/wdata at grant.
- IDLE: if only one requester, grant it; if both, grant the one not granted last (last_grant flag, reset = fetch, so LSB wins the first tie). Request inputs ignored in any cycle where done_to_lsb or end_to_fetcher is high; requester must drop its request the cycle after its completion pulse.
- FETCH: mem_a = base+cnt, cnt = 0..4*FETCH_WORDS-1, one per cycle; byte j captured from mem_din one cycle later into byte j%4 of the word register. After byte 4k+3 captured: one_inst_finish pulse (k < FETCH_WORDS-1) or end pulse (last word) with inst_to_fetcher valid; end returns to IDLE.
- LOAD: mem_a = addr+cnt, cnt < size; bytes captured as in FETCH; after last byte, done pulse with rdata (unused upper bytes 0), return IDLE.
- STORE: mem_wr=1, mem_a=addr+cnt, mem_dout=wdata byte cnt. If address in IO space and io_buffer_full, that cycle drives mem_wr=0 and cnt holds. After last byte written, done pulse, IDLE.
- reset_from_fetcher in FETCH: abort next edge to IDLE, no further pulses. In other states ignored.
- rollback_flag_from_rob in LOAD: abort to IDLE, no done (also suppresses a done that would occur that edge). STORE and FETCH unaffected; in IDLE, a pending load request is not granted that cycle.
- Address arithmetic wraps modulo 2^32.
- mem_a outside transfers holds last value; mem_wr=0 whenever not actively writing.

## Timing
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, available=1, all pulses 0, inst/rdata=0, state IDLE, last_grant=fetch.
- Grant: request seen in IDLE cycle t; cycle 0 of transfer = t+1; available drops in t+1.
- Fetch: pulse for word k in cycle 4k+5; end in cycle 4*FETCH_WORDS+1; available high that same cycle.
- Load size n: done in cycle n+1. Store size n (no stalls): done in cycle n; each IO stall cycle adds one.
- Pulses are registered, exactly one cycle wide; data outputs hold until next pulse.
- rdy_in low: no counter/state advance, captures suppressed; RAM model must hold read data alignment (address re-presented on resume).

## Test plan
- Async reset mid-FETCH (cycle 6 of burst at 0x1000) -> all outputs reset values immediately, available=1, no end pulse.
- Burst at 0x1000, RAM bytes = low address byte -> pulses cycles 5, 9, 13 with 0x03020100, 0x07060504, 0x0B0A0908; end cycle 17 with 0x0F0E0D0C.
- Load size 2 at 0x2002, RAM 0x34,0x12 -> done cycle 3, rdata 0x00001234; size 4 -> done cycle 5.
- Fetch and LSB request same cycle after reset -> LSB granted first, fetch follows; next tie grants fetch.
- Store size 1 to 0x30000, data 0x41, io_buffer_full high 3 cycles -> mem_wr first high cycle 3, done cycle 4; store to 0x100 size 4 -> 4 write cycles, done cycle 4.
- Rollback in cycle 2 of size-4 load -> no done, IDLE next cycle; pending fetch granted afterwards; rollback during FETCH -> burst completes normally.
